// File: rtl/zext_pkg.sv
// Shared widths, extension mode and skid-buffer state types for the zero/sign extender.
package zext_pkg;

    localparam int ZEXT_IN_W_DEF  = 4;
    localparam int ZEXT_OUT_W_DEF = 8;
    localparam int ZEXT_MAX_W     = 64;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_mode_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    // Extends the low in_w bits of data to the full ZEXT_MAX_W width; callers truncate.
    function automatic logic [ZEXT_MAX_W-1:0] ext_value(input logic [ZEXT_MAX_W-1:0] data,
                                                        input int in_w,
                                                        input ext_mode_e mode);
        logic [ZEXT_MAX_W-1:0] r;
        logic [5:0]            msb;
        logic                  fill;
        r    = data;
        msb  = 6'(in_w - 1);
        fill = (mode == EXT_SIGN) ? data[msb] : 1'b0;
        for (int i = 0; i < ZEXT_MAX_W; i++) begin
            if (i >= in_w) r[i] = fill;
        end
        return r;
    endfunction

endpackage

// File: rtl/zext_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; in_ready is registered so it never
// depends combinationally on out_ready.
module zext_skid_buf
    import zext_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    buf_state_e       state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             acc;

    assign acc      = in_valid && in_ready;
    assign out_data = main_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BUF_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    in_ready <= 1'b1;
                    if (acc) begin
                        main_q    <= in_data;
                        out_valid <= 1'b1;
                        state     <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (acc && !out_ready) begin
                        skid_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= BUF_TWO;
                    end else if (acc && out_ready) begin
                        // departing entry is replaced in the same cycle, no bubble
                        main_q <= in_data;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (out_ready) begin
                        main_q   <= skid_q;
                        in_ready <= 1'b1;
                        state    <= BUF_ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= BUF_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/zero_extender_pipe.sv
// Registered width extender: extends the operand at the input, then carries
// {mode, extended value} through a 2-entry skid buffer.
module zero_extender_pipe
    import zext_pkg::*;
#(
    parameter int IN_W  = ZEXT_IN_W_DEF,
    parameter int OUT_W = ZEXT_OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_sext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ext
);

    if (IN_W < 1 || OUT_W < IN_W || OUT_W > ZEXT_MAX_W) begin : g_bad_params
        $fatal(1, "zero_extender_pipe: need 1 <= IN_W <= OUT_W <= %0d", ZEXT_MAX_W);
    end

    logic [ZEXT_MAX_W-1:0] wide_in;
    logic [OUT_W-1:0]      ext;
    logic [OUT_W:0]        buf_out;

    assign wide_in = ZEXT_MAX_W'(in_data);
    assign ext     = OUT_W'(ext_value(wide_in, IN_W, ext_mode_e'(in_sext)));

    zext_skid_buf #(.WIDTH(OUT_W + 1)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_sext, ext}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

    assign out_ext  = buf_out[OUT_W];
    assign out_data = buf_out[OUT_W-1:0];

endmodule

// File: tb/tb_zero_extender_pipe.sv
// Directed bench for zero_extender_pipe: vector table plus backpressure, reset
// and parameter-width sequences.
module tb_zero_extender_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_sext, out_valid, out_ready, out_ext;
    logic [3:0] in_data;
    logic [7:0] out_data;

    // IN_W = OUT_W = 8 and IN_W = 1 instances
    logic       p8_valid, p8_ready, p8_sext, p8_ovalid, p8_ext;
    logic [7:0] p8_data, p8_out;
    logic       p1_valid, p1_ready, p1_sext, p1_ovalid, p1_ext;
    logic [0:0] p1_data;
    logic [7:0] p1_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    zero_extender_pipe #(.IN_W(4), .OUT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sext(in_sext), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ext(out_ext)
    );

    zero_extender_pipe #(.IN_W(8), .OUT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(p8_valid), .in_ready(p8_ready),
        .in_data(p8_data), .in_sext(p8_sext), .out_valid(p8_ovalid),
        .out_ready(1'b1), .out_data(p8_out), .out_ext(p8_ext)
    );

    zero_extender_pipe #(.IN_W(1), .OUT_W(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(p1_valid), .in_ready(p1_ready),
        .in_data(p1_data), .in_sext(p1_sext), .out_valid(p1_ovalid),
        .out_ready(1'b1), .out_data(p1_out), .out_ext(p1_ext)
    );

    typedef struct {
        logic [3:0] d;
        logic       s;
        logic [7:0] exp;
        logic       eext;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) vecs[i] = '{4'(i), 1'b0, 8'(i), 1'b0};
        vecs[16] = '{4'h7, 1'b1, 8'h07, 1'b1};
        vecs[17] = '{4'h8, 1'b1, 8'hF8, 1'b1};
        vecs[18] = '{4'hF, 1'b1, 8'hFF, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sext = 1'b0; out_ready = 1'b0;
        p8_valid = 1'b0; p8_data = '0; p8_sext = 1'b0;
        p1_valid = 1'b0; p1_data = '0; p1_sext = 1'b0;

        tick;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ext", 32'(out_ext), 0);
        rst = 1'b0;
        tick;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_out_valid", 32'(out_valid), 0);

        // streaming table: one per cycle, 1-cycle latency, no gaps
        out_ready = 1'b1;
        for (int i = 0; i < 19; i++) begin
            in_valid = 1'b1; in_data = vecs[i].d; in_sext = vecs[i].s;
            tick;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_ext", i), 32'(out_ext), 32'(vecs[i].eext));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 1);
        end
        in_valid = 1'b0;
        tick;
        chk("drain_valid", 32'(out_valid), 0);

        // backpressure: 0x3, 0x5 accepted, 0x9 held off
        out_ready = 1'b0; in_sext = 1'b0;
        in_valid = 1'b1; in_data = 4'h3;
        tick;
        chk("bp_first", 32'(out_data), 32'h03);
        chk("bp_ready1", 32'(in_ready), 1);
        in_data = 4'h5;
        tick;
        chk("bp_ready_full", 32'(in_ready), 0);
        chk("bp_hold1", 32'(out_data), 32'h03);
        in_data = 4'h9;
        tick;
        chk("bp_ready_still", 32'(in_ready), 0);
        chk("bp_hold2", 32'(out_data), 32'h03);
        chk("bp_hold_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        tick;
        chk("bp_second", 32'(out_data), 32'h05);
        chk("bp_ready_back", 32'(in_ready), 1);
        tick;
        chk("bp_third", 32'(out_data), 32'h09);
        in_valid = 1'b0;
        tick;
        chk("bp_drained", 32'(out_valid), 0);

        // reset with two entries buffered
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'hC;
        tick;
        in_data = 4'hD;
        tick;
        chk("mid_full", 32'(in_ready), 0);
        in_valid = 1'b0; rst = 1'b1;
        tick;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0; out_ready = 1'b1;
        tick;
        chk("mid_post_in_ready", 32'(in_ready), 1);
        chk("mid_post_valid", 32'(out_valid), 0);
        tick;
        chk("mid_no_old", 32'(out_valid), 0);

        // simultaneous transfer in ONE
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h1;
        tick;
        chk("sim_one", 32'(out_data), 32'h01);
        in_data = 4'hA; out_ready = 1'b1;
        tick;
        chk("sim_data", 32'(out_data), 32'h0A);
        chk("sim_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        tick;
        chk("sim_drain", 32'(out_valid), 0);

        // parameter sweep
        p8_valid = 1'b1; p8_data = 8'h80; p8_sext = 1'b0;
        p1_valid = 1'b1; p1_data = 1'b1;  p1_sext = 1'b1;
        tick;
        chk("p8_zero", 32'(p8_out), 32'h80);
        chk("p8_zero_ext", 32'(p8_ext), 0);
        chk("p1_sign", 32'(p1_out), 32'hFF);
        chk("p1_sign_ext", 32'(p1_ext), 1);
        p8_sext = 1'b1; p1_sext = 1'b0;
        tick;
        chk("p8_sign", 32'(p8_out), 32'h80);
        chk("p8_valid", 32'({p8_ovalid, p8_ready}), 32'h3);
        chk("p1_zero", 32'(p1_out), 32'h01);
        chk("p1_valid", 32'({p1_ovalid, p1_ready}), 32'h3);
        p8_valid = 1'b0; p1_valid = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
